// File: rtl/sdram_read.sv
// sdram_read: page-burst read engine for the SDR SDRAM controller.
// ACTIVE -> tRCD -> READ -> CAS/data -> BURST STOP -> PRECHARGE -> tRP.
module sdram_read #(
  parameter int TRCD_CLK = 2,
  parameter int TRP_CLK  = 2,
  parameter int CAS_LAT  = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        rd_en,
  input  logic [23:0] rd_addr,
  input  logic [9:0]  rd_burst_len,
  input  logic [15:0] rd_sdram_data,
  output logic        rd_act,
  output logic        rd_end,
  output logic [3:0]  read_cmd,
  output logic [1:0]  read_ba,
  output logic [12:0] read_addr,
  output logic [15:0] rd_data,
  output logic        rd_data_valid
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_BS  = 4'b0110;
  localparam logic [3:0] CMD_PC  = 4'b0010;

  localparam logic [9:0] TRCD_LAST = 10'(TRCD_CLK - 1);
  localparam logic [9:0] TRP_LAST  = 10'(TRP_CLK - 1);
  localparam logic [9:0] CL        = 10'(CAS_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_TRCD,
    S_READ,
    S_DATA,
    S_PRE,
    S_TRP,
    S_END
  } state_t;

  state_t      state;
  logic [9:0]  cnt;
  logic [1:0]  bank_q;
  logic [12:0] row_q;
  logic [8:0]  col_q;
  logic [9:0]  len_q;
  logic [9:0]  data_last;
  logic        in_window;

  // DATA lasts LEN words plus the CAS latency; DQ is live in the tail
  assign data_last = len_q + CL - 10'd1;
  assign in_window = (cnt >= CL) && (cnt <= data_last);

  // FSM, burst latches and registered command/data outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bank_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      len_q         <= '0;
      read_cmd      <= CMD_NOP;
      read_ba       <= 2'b11;
      read_addr     <= 13'h1FFF;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      rd_act        <= 1'b0;
      rd_end        <= 1'b0;
    end else begin
      read_cmd      <= CMD_NOP;
      read_ba       <= 2'b11;
      read_addr     <= 13'h1FFF;
      rd_data_valid <= 1'b0;
      rd_act        <= 1'b0;
      rd_end        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (init_end && rd_en) begin
            state  <= S_ACTIVE;
            bank_q <= rd_addr[23:22];
            row_q  <= rd_addr[21:9];
            col_q  <= rd_addr[8:0];
            len_q  <= (rd_burst_len == 10'd0) ?
                      10'd1 : rd_burst_len;
          end
        end
        S_ACTIVE: begin
          read_cmd  <= CMD_ACT;
          read_ba   <= bank_q;
          read_addr <= row_q;
          cnt       <= '0;
          state     <= S_TRCD;
        end
        S_TRCD: begin
          if (cnt == TRCD_LAST) begin
            cnt    <= '0;
            rd_act <= 1'b1;
            state  <= S_READ;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        S_READ: begin
          read_cmd  <= CMD_RD;
          read_ba   <= bank_q;
          read_addr <= {4'b0000, col_q};
          cnt       <= '0;
          state     <= S_DATA;
        end
        S_DATA: begin
          if (cnt == len_q - 10'd1) begin
            read_cmd <= CMD_BS;
          end
          if (in_window) begin
            rd_data       <= rd_sdram_data;
            rd_data_valid <= 1'b1;
          end
          if (cnt == data_last) begin
            cnt   <= '0;
            state <= S_PRE;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        S_PRE: begin
          read_cmd  <= CMD_PC;
          read_ba   <= bank_q;
          read_addr <= 13'h0400;
          cnt       <= '0;
          state     <= S_TRP;
        end
        S_TRP: begin
          if (cnt == TRP_LAST) begin
            cnt    <= '0;
            rd_end <= 1'b1;
            state  <= S_END;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        S_END: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_read.sv
// tb_sdram_read: two engines (CAS 3 and CAS 2) against a cycle-offset
// model and a small SDRAM responder that drives DQ from the command bus.
module tb_sdram_read;

  localparam int TRCD = 2;
  localparam int TRP  = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_end;
  logic        rd_en;
  logic [23:0] rd_addr;
  logic [9:0]  rd_burst_len;

  logic [15:0] dq      [2];
  logic        act_o   [2];
  logic        end_o   [2];
  logic [3:0]  cmd_o   [2];
  logic [1:0]  ba_o    [2];
  logic [12:0] addr_o  [2];
  logic [15:0] data_o  [2];
  logic        val_o   [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit checking = 1'b0;

  always #5 sys_clk = ~sys_clk;

  sdram_read #(.TRCD_CLK(2), .TRP_CLK(2), .CAS_LAT(3)) u_cl3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_burst_len(rd_burst_len),
    .rd_sdram_data(dq[0]), .rd_act(act_o[0]), .rd_end(end_o[0]),
    .read_cmd(cmd_o[0]), .read_ba(ba_o[0]), .read_addr(addr_o[0]),
    .rd_data(data_o[0]), .rd_data_valid(val_o[0])
  );

  sdram_read #(.TRCD_CLK(2), .TRP_CLK(2), .CAS_LAT(2)) u_cl2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_burst_len(rd_burst_len),
    .rd_sdram_data(dq[1]), .rd_act(act_o[1]), .rd_end(end_o[1]),
    .read_cmd(cmd_o[1]), .read_ba(ba_o[1]), .read_addr(addr_o[1]),
    .rd_data(data_o[1]), .rd_data_valid(val_o[1])
  );

  function automatic int cl_of(input int d);
    return (d == 0) ? 3 : 2;
  endfunction

  // SDRAM contents: a fixed function of bank/row/column
  function automatic logic [15:0] mem_word(input logic [1:0] ba,
                                           input logic [12:0] row,
                                           input int col);
    int v;
    v = int'(row) * 7 + (col % 512) * 13 + int'(ba) * 4099 + 23130;
    return v[15:0];
  endfunction

  // ---------------- behavioural model ----------------
  bit          busy   [2];
  int          m_a    [2];
  int          m_nxt  [2];
  int          m_len  [2];
  logic [1:0]  m_ba   [2];
  logic [12:0] m_row  [2];
  logic [8:0]  m_col  [2];
  logic [15:0] last_d [2];

  logic [3:0]  e_cmd  [2];
  logic [1:0]  e_ba   [2];
  logic [12:0] e_addr [2];
  logic        e_act  [2];
  logic        e_end  [2];
  logic        e_val  [2];
  logic [15:0] e_data [2];

  task automatic model_step(input int d);
    int cl, r, e, i;
    cl = cl_of(d);
    e_cmd[d]  = 4'b0111;
    e_ba[d]   = 2'b11;
    e_addr[d] = 13'h1FFF;
    e_act[d]  = 1'b0;
    e_end[d]  = 1'b0;
    e_val[d]  = 1'b0;
    if (sys_rst) begin
      busy[d]   = 1'b0;
      m_nxt[d]  = cyc + 1;
      last_d[d] = '0;
      e_data[d] = '0;
      return;
    end
    if (busy[d]) begin
      e = m_a[d] + TRCD + 2 + m_len[d] + cl + TRP + 1;
      if (cyc > e) begin
        busy[d]  = 1'b0;
        m_nxt[d] = e + 2;
      end
    end
    if (!busy[d] && cyc >= m_nxt[d] && init_end && rd_en) begin
      busy[d]  = 1'b1;
      m_a[d]   = cyc;
      m_ba[d]  = rd_addr[23:22];
      m_row[d] = rd_addr[21:9];
      m_col[d] = rd_addr[8:0];
      m_len[d] = (rd_burst_len == 10'd0) ? 1 : int'(rd_burst_len);
    end
    if (busy[d]) begin
      r = m_a[d] + TRCD + 2;
      e = r + m_len[d] + cl + TRP + 1;
      if (cyc == m_a[d] + 1) begin
        e_cmd[d]  = 4'b0011;
        e_ba[d]   = m_ba[d];
        e_addr[d] = m_row[d];
      end else if (cyc == r) begin
        e_cmd[d]  = 4'b0101;
        e_ba[d]   = m_ba[d];
        e_addr[d] = {4'b0000, m_col[d]};
      end else if (cyc == r + m_len[d]) begin
        e_cmd[d]  = 4'b0110;
      end else if (cyc == r + m_len[d] + cl + 1) begin
        e_cmd[d]  = 4'b0010;
        e_ba[d]   = m_ba[d];
        e_addr[d] = 13'h0400;
      end
      e_act[d] = (cyc == r - 1);
      e_end[d] = (cyc == e);
      if (cyc >= r + cl + 1 && cyc <= r + cl + m_len[d]) begin
        i = cyc - (r + cl + 1);
        e_val[d]  = 1'b1;
        last_d[d] = mem_word(m_ba[d], m_row[d], int'(m_col[d]) + i);
      end
    end
    e_data[d] = last_d[d];
  endtask

  // advance the model on every active edge
  always @(posedge sys_clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) model_step(d);
  end

  // compare every output of both engines each cycle
  always @(negedge sys_clk) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        tests = tests + 1;
        if ({cmd_o[d], ba_o[d], addr_o[d], act_o[d], end_o[d],
             val_o[d], data_o[d]} !==
            {e_cmd[d], e_ba[d], e_addr[d], e_act[d], e_end[d],
             e_val[d], e_data[d]}) begin
          fails = fails + 1;
          $display("FAIL model dut%0d cyc %0d got cmd=%b ba=%b addr=%h act=%b end=%b val=%b data=%h want cmd=%b ba=%b addr=%h act=%b end=%b val=%b data=%h",
                   d, cyc, cmd_o[d], ba_o[d], addr_o[d], act_o[d],
                   end_o[d], val_o[d], data_o[d], e_cmd[d], e_ba[d],
                   e_addr[d], e_act[d], e_end[d], e_val[d], e_data[d]);
        end
      end
    end
  end

  // ---------------- SDRAM responder + event recorder ----------------
  bit          s_on   [2];
  int          s_r    [2];
  int          s_stop [2];
  logic [1:0]  s_ba   [2];
  logic [12:0] s_row  [2];
  logic [8:0]  s_col  [2];

  int t_act [2], t_rd [2], t_bs [2], t_v0 [2], t_end [2], gap [2];
  int vcnt [2], vruns [2], nact [2], nend [2], ncmd [2], pc_cnt [2];
  logic [1:0]  act_ba  [2];
  logic [12:0] act_adr [2];
  logic [12:0] rd_adr  [2];
  logic [12:0] pc_adr  [2];
  bit          pv      [2];

  task automatic clear_rec();
    for (int d = 0; d < 2; d++) begin
      t_act[d] = 0; t_rd[d] = 0; t_bs[d] = 0; t_v0[d] = 0;
      t_end[d] = -1; gap[d] = 0; vcnt[d] = 0; vruns[d] = 0;
      nact[d] = 0; nend[d] = 0; ncmd[d] = 0; pc_cnt[d] = 0;
      act_ba[d] = '0; act_adr[d] = '0; rd_adr[d] = '0;
      pc_adr[d] = '0;
    end
  endtask

  always @(negedge sys_clk) begin
    for (int d = 0; d < 2; d++) begin
      int cl;
      cl = cl_of(d);
      case (cmd_o[d])
        4'b0011: begin
          s_row[d] = addr_o[d];
          t_act[d] = cyc; act_ba[d] = ba_o[d]; act_adr[d] = addr_o[d];
        end
        4'b0101: begin
          s_on[d] = 1'b1; s_r[d] = cyc; s_stop[d] = 1 << 30;
          s_ba[d] = ba_o[d]; s_col[d] = addr_o[d][8:0];
          t_rd[d] = cyc; rd_adr[d] = addr_o[d];
        end
        4'b0110: begin
          s_stop[d] = cyc; t_bs[d] = cyc;
        end
        4'b0010: begin
          pc_adr[d] = addr_o[d]; pc_cnt[d] = pc_cnt[d] + 1;
        end
        default: ;
      endcase
      if (cmd_o[d] !== 4'b0111) ncmd[d] = ncmd[d] + 1;
      if (s_on[d] && cyc >= s_r[d] + cl && cyc <= s_stop[d] + cl - 1)
        dq[d] = mem_word(s_ba[d], s_row[d],
                         int'(s_col[d]) + cyc - s_r[d] - cl);
      else
        dq[d] = 16'hDEAD ^ 16'(cyc);
      if (act_o[d] === 1'b1) begin
        nact[d] = nact[d] + 1;
        if (t_end[d] >= 0) gap[d] = cyc - t_end[d];
      end
      if (end_o[d] === 1'b1) begin
        nend[d] = nend[d] + 1; t_end[d] = cyc;
      end
      if (val_o[d] === 1'b1) begin
        vcnt[d] = vcnt[d] + 1;
        if (!pv[d]) begin
          vruns[d] = vruns[d] + 1;
          if (vruns[d] == 1) t_v0[d] = cyc;
        end
      end
      pv[d] = (val_o[d] === 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input int got, input int want);
    tests = tests + 1;
    if (got !== want) begin
      fails = fails + 1;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  task automatic pulse(input logic [23:0] a, input logic [9:0] len);
    step(1);
    rd_addr = a; rd_burst_len = len; rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    rd_addr = 24'($urandom);
    rd_burst_len = 10'($urandom);
  endtask

  initial begin
    sys_rst = 1'b1; init_end = 1'b1; rd_en = 1'b0;
    rd_addr = '0; rd_burst_len = '0;
    for (int d = 0; d < 2; d++) begin
      dq[d] = '0; s_on[d] = 1'b0; s_r[d] = 0; s_stop[d] = 0;
      pv[d] = 1'b0; busy[d] = 1'b0; m_nxt[d] = 0;
    end
    clear_rec();
    step(3);
    checking = 1'b1;
    chk("reset_cmd", int'(cmd_o[0]), 7);
    chk("reset_ba", int'(ba_o[1]), 3);
    chk("reset_addr", int'(addr_o[0]), 'h1FFF);
    chk("reset_data", int'(data_o[0]), 0);
    sys_rst = 1'b0;
    step(2);

    // basic LEN=8 burst
    clear_rec();
    pulse(24'h403A10, 10'd8);
    step(30);
    chk("t1_act_ba", int'(act_ba[0]), 1);
    chk("t1_act_row", int'(act_adr[0]), 'h001D);
    chk("t1_act_to_read", t_rd[0] - t_act[0], 3);
    chk("t1_read_addr", int'(rd_adr[0]), 'h0010);
    chk("t1_bstop", t_bs[0] - t_rd[0], 8);
    chk("t1_vcnt", vcnt[0], 8);
    chk("t1_first_valid", t_v0[0] - t_rd[0], 4);
    chk("t1_vruns", vruns[0], 1);
    chk("t1_rd_end", nend[0], 1);
    chk("t1_rd_act", nact[0], 1);
    chk("t1_cl2_first_valid", t_v0[1] - t_rd[1], 3);

    // LEN=1 and LEN=0
    for (int k = 0; k < 2; k++) begin
      clear_rec();
      pulse(24'($urandom), (k == 0) ? 10'd1 : 10'd0);
      step(25);
      chk("t2_bstop", t_bs[0] - t_rd[0], 1);
      chk("t2_vcnt_cl3", vcnt[0], 1);
      chk("t2_vcnt_cl2", vcnt[1], 1);
      chk("t2_pchg_addr", int'(pc_adr[0]), 'h0400);
      chk("t2_pchg_cnt", pc_cnt[0], 1);
    end

    // rd_en held for three bursts
    clear_rec();
    rd_addr = 24'($urandom); rd_burst_len = 10'd4; rd_en = 1'b1;
    for (int k = 0; k < 300 && nend[0] < 3; k++) step(1);
    rd_en = 1'b0;
    chk("t3_rd_act", nact[0], 3);
    chk("t3_rd_end", nend[0], 3);
    chk("t3_end_to_act", gap[0], 5);
    step(40);

    // no init_end -> nothing issued
    clear_rec();
    init_end = 1'b0; rd_en = 1'b1;
    step(20);
    rd_en = 1'b0; init_end = 1'b1;
    chk("t4_cmds_cl3", ncmd[0], 0);
    chk("t4_cmds_cl2", ncmd[1], 0);
    chk("t4_rd_act", nact[0], 0);
    step(2);

    // reset during DATA cnt=2 of a LEN=16 burst
    clear_rec();
    pulse(24'($urandom), 10'd16);
    step(3);
    chk("t5_rd_act", int'(act_o[0]), 1);
    step(3);
    sys_rst = 1'b1;
    step(1);
    chk("t5_cmd", int'(cmd_o[0]), 7);
    chk("t5_ba", int'(ba_o[0]), 3);
    chk("t5_addr", int'(addr_o[0]), 'h1FFF);
    chk("t5_valid", int'(val_o[0]), 0);
    sys_rst = 1'b0;
    clear_rec();
    pulse(24'($urandom), 10'd5);
    step(30);
    chk("t5_after_vcnt", vcnt[0], 5);
    chk("t5_after_end", nend[0], 1);

    // full page
    clear_rec();
    pulse(24'($urandom), 10'd512);
    step(560);
    chk("t6_vcnt_cl2", vcnt[1], 512);
    chk("t6_vruns_cl2", vruns[1], 1);
    chk("t6_first_valid_cl2", t_v0[1] - t_rd[1], 3);
    chk("t6_bstop_cl2", t_bs[1] - t_rd[1], 512);
    chk("t6_vcnt_cl3", vcnt[0], 512);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      rd_en = ($urandom % 4 == 0);
      init_end = ($urandom % 16 != 0);
      rd_addr = 24'($urandom);
      rd_burst_len = ($urandom % 10 == 0) ?
                     10'($urandom_range(100, 512)) :
                     10'($urandom_range(0, 24));
      sys_rst = ($urandom % 500 == 0);
      step(1);
    end
    sys_rst = 1'b0; rd_en = 1'b0; init_end = 1'b1;
    step(600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
